// File: rtl/mux21_bist.sv
// Built-in self-test for a 2:1 mux: drives all {A,B,SEL} vectors,
// checks OUT_IN, counts mismatches, reports PASS/DONE.
//
// Ports: CLK, RST_N (async low), START, OUT_IN in; A/B/SEL drives,
// BUSY, DONE, PASS, ERR_CNT[CNT_W], FAIL_VEC[4] out.
// Optional: MUX21_BIST_FAILCAP_EN enables first-fail vector capture.
module mux21_bist #(
  parameter int SETTLE = 2,
  parameter int CNT_W  = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic             OUT_IN,
  output logic             A,
  output logic             B,
  output logic             SEL,
  output logic             BUSY,
  output logic             DONE,
  output logic             PASS,
  output logic [CNT_W-1:0] ERR_CNT,
  output logic [3:0]       FAIL_VEC
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_WAIT,
    S_CMP,
    S_DONE
  } state_t;

  localparam logic [3:0]       SET_W   = 4'(SETTLE);
  localparam logic [CNT_W-1:0] ERR_MAX = '1;

  state_t           state;
  logic [2:0]       idx;
  logic [3:0]       wcnt;
  logic             miss;
  logic             start_ok;
  logic [CNT_W-1:0] err_nxt;

  assign miss     = OUT_IN != (SEL ? B : A);
  assign start_ok = START &&
                    (state == S_IDLE || state == S_DONE);

  always_comb begin
    err_nxt = ERR_CNT;
    if (miss && ERR_CNT != ERR_MAX)
      err_nxt = ERR_CNT + CNT_W'(1);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= S_IDLE;
      idx     <= 3'd0;
      wcnt    <= 4'd0;
      A       <= 1'b0;
      B       <= 1'b0;
      SEL     <= 1'b0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      PASS    <= 1'b0;
      ERR_CNT <= '0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (START) begin
            state        <= S_DRIVE;
            idx          <= 3'd0;
            {A, B, SEL}  <= 3'b000;
            ERR_CNT      <= '0;
            BUSY         <= 1'b1;
            DONE         <= 1'b0;
            PASS         <= 1'b0;
          end
        end
        S_DRIVE: begin
          wcnt  <= SET_W - 4'd1;
          state <= (SETTLE == 0) ? S_CMP : S_WAIT;
        end
        S_WAIT: begin
          if (wcnt == 4'd0)
            state <= S_CMP;
          else
            wcnt <= wcnt - 4'd1;
        end
        S_CMP: begin
          ERR_CNT <= err_nxt;
          if (idx == 3'd7) begin
            state <= S_DONE;
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
            PASS  <= (err_nxt == '0);
          end else begin
            idx         <= idx + 3'd1;
            {A, B, SEL} <= idx + 3'd1;
            state       <= S_DRIVE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef MUX21_BIST_FAILCAP_EN
  logic [3:0] fail_q;

  // Only the first miss of a run is kept; bit 3 marks it taken.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)
      fail_q <= 4'b0000;
    else if (start_ok)
      fail_q <= 4'b0000;
    else if (state == S_CMP && miss && !fail_q[3])
      fail_q <= {1'b1, A, B, SEL};
  end

  assign FAIL_VEC = fail_q;
`else
  logic unused_ok;
  assign unused_ok = start_ok;
  assign FAIL_VEC  = 4'b0000;
`endif

endmodule

// File: tb/tb_mux21_bist.sv
// Scoreboard bench for mux21_bist: two instances (default and
// SETTLE=0/CNT_W=2), behavioural mux models with injected faults.
module tb_mux21_bist;

`ifdef MUX21_BIST_FAILCAP_EN
  localparam logic [3:0] FV_STUCK = 4'b1011;
  localparam logic [3:0] FV_INV   = 4'b1010;
  localparam logic [3:0] FV_WRONG = 4'b1000;
`else
  localparam logic [3:0] FV_STUCK = 4'b0000;
  localparam logic [3:0] FV_INV   = 4'b0000;
  localparam logic [3:0] FV_WRONG = 4'b0000;
`endif

  typedef struct {
    int         lat;
    logic [3:0] err;
    logic       pass;
    logic [3:0] fv;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start0 = 1'b0;
  logic start1 = 1'b0;
  int   mode0 = 0;
  int   mode1 = 0;
  int   cyc = 0;
  int   st0 = 0;
  int   st1 = 0;
  int   cmp_n = 0;
  int   bad_n = 0;

  logic       out0, a0, b0, s0, busy0, done0, pass0;
  logic [3:0] err0, fv0;
  logic       out1, a1, b1, s1, busy1, done1, pass1;
  logic [1:0] err1;
  logic [3:0] fv1;

  exp_t       q0[$];
  exp_t       q1[$];
  logic [2:0] vlog0[$];
  logic [2:0] vlog1[$];
  logic       dprev0 = 1'b0;
  logic       dprev1 = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // 0 good, 1 stuck-at-0, 2 inverted select, 3 always wrong
  function automatic logic mux_model(int m, logic a, logic b, logic s);
    case (m)
      1:       return 1'b0;
      2:       return s ? a : b;
      3:       return ~(s ? b : a);
      default: return s ? b : a;
    endcase
  endfunction

  assign out0 = mux_model(mode0, a0, b0, s0);
  assign out1 = mux_model(mode1, a1, b1, s1);

  mux21_bist u0 (
    .CLK(clk), .RST_N(rst_n), .START(start0), .OUT_IN(out0),
    .A(a0), .B(b0), .SEL(s0), .BUSY(busy0), .DONE(done0),
    .PASS(pass0), .ERR_CNT(err0), .FAIL_VEC(fv0)
  );

  mux21_bist #(.SETTLE(0), .CNT_W(2)) u1 (
    .CLK(clk), .RST_N(rst_n), .START(start1), .OUT_IN(out1),
    .A(a1), .B(b1), .SEL(s1), .BUSY(busy1), .DONE(done1),
    .PASS(pass1), .ERR_CNT(err1), .FAIL_VEC(fv1)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    cmp_n++;
    if (act !== exp) begin
      bad_n++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor for u0: logs vectors while busy, checks on DONE rise.
  always @(negedge clk) begin
    exp_t e;
    bit   ok;
    if (rst_n && done0 && !dprev0) begin
      chk("u0 exp pending", q0.size() != 0, 1);
      if (q0.size() != 0) begin
        e = q0.pop_front();
        chk("u0 latency", cyc - st0, e.lat);
        chk("u0 err_cnt", err0, e.err);
        chk("u0 pass", pass0, e.pass);
        chk("u0 fail_vec", fv0, e.fv);
        ok = (vlog0.size() == 32);
        foreach (vlog0[i])
          if (vlog0[i] != 3'(i / 4)) ok = 0;
        chk("u0 vector hold", ok, 1);
      end
    end
    if (busy0) vlog0.push_back({a0, b0, s0});
    dprev0 = done0;
  end

  always @(negedge clk) begin
    exp_t e;
    bit   ok;
    if (rst_n && done1 && !dprev1) begin
      chk("u1 exp pending", q1.size() != 0, 1);
      if (q1.size() != 0) begin
        e = q1.pop_front();
        chk("u1 latency", cyc - st1, e.lat);
        chk("u1 err_cnt", {2'b00, err1}, e.err);
        chk("u1 pass", pass1, e.pass);
        chk("u1 fail_vec", fv1, e.fv);
        ok = (vlog1.size() == 16);
        foreach (vlog1[i])
          if (vlog1[i] != 3'(i / 2)) ok = 0;
        chk("u1 vector hold", ok, 1);
      end
    end
    if (busy1) vlog1.push_back({a1, b1, s1});
    dprev1 = done1;
  end

  task automatic go0(input int m, input bit push, input logic [3:0] e,
                     input logic p, input logic [3:0] fv);
    @(negedge clk);
    mode0  = m;
    start0 = 1'b1;
    st0    = cyc + 1;
    vlog0.delete();
    if (push) q0.push_back('{32, e, p, fv});
    @(negedge clk);
    start0 = 1'b0;
    chk("u0 busy after start", {busy0, done0, a0, b0, s0}, 5'b10000);
  endtask

  task automatic go1(input int m, input logic [3:0] e, input logic p,
                     input logic [3:0] fv);
    @(negedge clk);
    mode1  = m;
    start1 = 1'b1;
    st1    = cyc + 1;
    vlog1.delete();
    q1.push_back('{16, e, p, fv});
    @(negedge clk);
    start1 = 1'b0;
    chk("u1 busy after start", {busy1, done1, a1, b1, s1}, 5'b10000);
  endtask

  task automatic wait0(input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done0) seen = 1;
    end
    chk("u0 done seen", seen, 1);
    @(negedge clk);
  endtask

  task automatic wait1(input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done1) seen = 1;
    end
    chk("u1 done seen", seen, 1);
    @(negedge clk);
  endtask

  initial begin
    bit found;
    #12;
    chk("u0 reset", {a0, b0, s0, busy0, done0, pass0, err0, fv0}, 0);
    chk("u1 reset", {a1, b1, s1, busy1, done1, pass1, err1, fv1}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    go0(0, 1, 4'd0, 1'b1, 4'b0000);
    wait0(40);
    go0(1, 1, 4'd4, 1'b0, FV_STUCK);
    wait0(40);
    go0(2, 1, 4'd4, 1'b0, FV_INV);
    wait0(40);

    go0(0, 1, 4'd0, 1'b1, 4'b0000);
    repeat (9) @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    chk("u0 mid-start ignored", busy0, 1);
    wait0(40);

    go0(0, 0, 4'd0, 1'b0, 4'b0000);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (busy0 && {a0, b0, s0} == 3'b101) found = 1;
      else @(negedge clk);
    end
    chk("u0 reached vector 5", found, 1);
    rst_n = 1'b0;
    #1;
    chk("u0 async reset", {a0, b0, s0, busy0, done0, pass0, err0, fv0}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    go0(0, 1, 4'd0, 1'b1, 4'b0000);
    wait0(40);

    go1(0, 4'd0, 1'b1, 4'b0000);
    wait1(24);
    go1(3, 4'd3, 1'b0, FV_WRONG);
    wait1(24);
    go1(1, 4'd3, 1'b0, FV_STUCK);
    wait1(24);

    repeat (3) @(negedge clk);
    chk("u0 scoreboard drained", q0.size(), 0);
    chk("u1 scoreboard drained", q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             cmp_n, bad_n);
    $finish;
  end

endmodule
